// File: rtl/l3fwd_mat_pkg.sv
// Shared constants for the L3 forwarding match-action unit: CSR word offsets,
// header field positions and the CSR byte-strobe merge helper.
package l3fwd_mat_pkg;

    localparam logic [31:0] CSR_INDEX    = 32'h0000_0010;
    localparam logic [31:0] CSR_VALUE    = 32'h0000_0014;
    localparam logic [31:0] CSR_MASK     = 32'h0000_0018;
    localparam logic [31:0] CSR_CMD      = 32'h0000_001C;
    localparam logic [31:0] CSR_ACTION0  = 32'h0000_0020;
    localparam logic [31:0] CSR_ACTION1  = 32'h0000_0024;
    localparam logic [31:0] CSR_ACTION2  = 32'h0000_0028;
    localparam logic [31:0] CSR_ACTION3  = 32'h0000_002C;
    localparam logic [31:0] CSR_HIT_CNT  = 32'h0000_0030;
    localparam logic [31:0] CSR_MISS_CNT = 32'h0000_0034;

    localparam int CMD_COMMIT_BIT = 0;
    localparam int CMD_VALID_BIT  = 1;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam int ETH_TYPE_BYTE = 12;
    localparam int KEY_BYTE      = 30;

    // Byte-lane merge of a CSR write into the current register contents.
    function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic csr_in_range(input logic [31:0] word_addr);
        return (word_addr >= CSR_INDEX) && (word_addr <= CSR_MISS_CNT);
    endfunction

endpackage

// File: rtl/l3fwd_mat_tcam.sv
// Ternary match table: per-entry value/mask/action storage, single commit
// write port, combinational lowest-index-wins priority match.
module l3fwd_mat_tcam
    import l3fwd_mat_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int KEY_WIDTH  = 32,
    parameter int ACTN_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [KEY_WIDTH-1:0]  wr_value,
    input  logic [KEY_WIDTH-1:0]  wr_mask,
    input  logic [ACTN_WIDTH-1:0] wr_action,
    input  logic                  wr_valid,
    input  logic [KEY_WIDTH-1:0]  key,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] hit_index,
    output logic [ACTN_WIDTH-1:0] hit_action
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0]      valid;
    logic [KEY_WIDTH-1:0]  value_mem  [DEPTH];
    logic [KEY_WIDTH-1:0]  mask_mem   [DEPTH];
    logic [ACTN_WIDTH-1:0] action_mem [DEPTH];

    // Only the valid bits need reset; payload is ignored while invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_addr] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            value_mem[wr_addr]  <= wr_value;
            mask_mem[wr_addr]   <= wr_mask;
            action_mem[wr_addr] <= wr_action;
        end
    end

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        hit        = 1'b0;
        hit_index  = '0;
        hit_action = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && ((key & mask_mem[i]) == (value_mem[i] & mask_mem[i]))) begin
                hit        = 1'b1;
                hit_index  = ADDR_WIDTH'(i);
                hit_action = action_mem[i];
            end
        end
    end

endmodule

// File: rtl/l3fwd_mat.sv
// L3 forwarding match-action: looks up the IPv4 destination of each packet in
// a ternary table and appends the matched action word to tuser on every beat.
module l3fwd_mat
    import l3fwd_mat_pkg::*;
#(
    parameter int S_DATA_WIDTH    = 512,
    parameter int S_KEEP_WIDTH    = S_DATA_WIDTH / 8,
    parameter int S_ID_WIDTH      = 8,
    parameter int S_DEST_WIDTH    = 4,
    parameter int S_USER_WIDTH    = 4,
    parameter int REG_ADDR_WIDTH  = 16,
    parameter int REG_DATA_WIDTH  = 32,
    parameter int TCAM_ADDR_WIDTH = 10,
    parameter int TCAM_WR_WIDTH   = 32,
    parameter int ACTN_DATA_WIDTH = 128,
    parameter int M_USER_WIDTH    = S_USER_WIDTH + ACTN_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [S_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [S_ID_WIDTH-1:0]       s_axis_tid,
    input  logic [S_DEST_WIDTH-1:0]     s_axis_tdest,
    input  logic [S_USER_WIDTH-1:0]     s_axis_tuser,

    output logic [S_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [S_KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [S_ID_WIDTH-1:0]       m_axis_tid,
    output logic [S_DEST_WIDTH-1:0]     m_axis_tdest,
    output logic [M_USER_WIDTH-1:0]     m_axis_tuser,

    input  logic [REG_ADDR_WIDTH-1:0]   reg_wr_addr,
    input  logic [REG_DATA_WIDTH-1:0]   reg_wr_data,
    input  logic [REG_DATA_WIDTH/8-1:0] reg_wr_strb,
    input  logic                        reg_wr_en,
    output logic                        reg_wr_wait,
    output logic                        reg_wr_ack,
    input  logic [REG_ADDR_WIDTH-1:0]   reg_rd_addr,
    input  logic                        reg_rd_en,
    output logic [REG_DATA_WIDTH-1:0]   reg_rd_data,
    output logic                        reg_rd_wait,
    output logic                        reg_rd_ack
);

    // Stream handshake: a beat transfers on a rising edge where valid and
    // ready are both high; valid and payload hold until that transfer, and the
    // single output register accepts a new beat whenever it is empty or draining.
    logic s_hs;
    assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
    assign s_hs          = s_axis_tvalid & s_axis_tready;

    logic                       first_beat;
    logic [ACTN_DATA_WIDTH-1:0] act_reg;
    logic [15:0]                eth_type;
    logic [TCAM_WR_WIDTH-1:0]   key;
    logic                       is_ipv4;
    logic                       tcam_hit;
    logic [TCAM_ADDR_WIDTH-1:0] unused_hit_index;
    logic [ACTN_DATA_WIDTH-1:0] tcam_action;
    logic                       pkt_hit;
    logic [ACTN_DATA_WIDTH-1:0] beat_act;

    assign eth_type = {s_axis_tdata[8*ETH_TYPE_BYTE +: 8], s_axis_tdata[8*(ETH_TYPE_BYTE+1) +: 8]};
    assign key      = {s_axis_tdata[8*KEY_BYTE +: 8],     s_axis_tdata[8*(KEY_BYTE+1) +: 8],
                       s_axis_tdata[8*(KEY_BYTE+2) +: 8], s_axis_tdata[8*(KEY_BYTE+3) +: 8]};
    assign is_ipv4  = (eth_type == ETH_TYPE_IPV4);
    assign pkt_hit  = is_ipv4 & tcam_hit;
    assign beat_act = first_beat ? (pkt_hit ? tcam_action : '0) : act_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
            m_axis_tuser  <= '0;
            first_beat    <= 1'b1;
            act_reg       <= '0;
        end else begin
            if (s_hs) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tid    <= s_axis_tid;
                m_axis_tdest  <= s_axis_tdest;
                m_axis_tuser  <= {beat_act, s_axis_tuser};
                act_reg       <= beat_act;
                first_beat    <= s_axis_tlast;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // CSR staging registers and write decode.
    logic [TCAM_ADDR_WIDTH-1:0] index_reg;
    logic [TCAM_WR_WIDTH-1:0]   value_reg;
    logic [TCAM_WR_WIDTH-1:0]   mask_reg;
    logic [3:0][31:0]           act_w;
    logic [31:0]                hit_cnt;
    logic [31:0]                miss_cnt;
    logic [31:0]                wr_word;
    logic [31:0]                rd_word;
    logic                       wr_accept;
    logic                       rd_accept;
    logic                       commit;
    logic                       cnt_clear;
    logic [31:0]                rd_mux;

    assign wr_word   = 32'(reg_wr_addr) & 32'hFFFF_FFFC;
    assign rd_word   = 32'(reg_rd_addr) & 32'hFFFF_FFFC;
    assign wr_accept = reg_wr_en & ~reg_wr_ack & csr_in_range(wr_word);
    assign rd_accept = reg_rd_en & ~reg_rd_ack & csr_in_range(rd_word);
    assign commit    = wr_accept & (wr_word == CSR_CMD) & reg_wr_strb[0] & reg_wr_data[CMD_COMMIT_BIT];
    assign cnt_clear = wr_accept & (wr_word == CSR_MISS_CNT);

    assign reg_wr_wait = 1'b0;
    assign reg_rd_wait = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_reg  <= '0;
            value_reg  <= '0;
            mask_reg   <= '0;
            act_w      <= '0;
            reg_wr_ack <= 1'b0;
        end else begin
            reg_wr_ack <= wr_accept;
            if (wr_accept) begin
                case (wr_word)
                    CSR_INDEX:   index_reg <= TCAM_ADDR_WIDTH'(apply_strb(32'(index_reg), reg_wr_data, reg_wr_strb));
                    CSR_VALUE:   value_reg <= apply_strb(value_reg, reg_wr_data, reg_wr_strb);
                    CSR_MASK:    mask_reg  <= apply_strb(mask_reg, reg_wr_data, reg_wr_strb);
                    CSR_ACTION0: act_w[0]  <= apply_strb(act_w[0], reg_wr_data, reg_wr_strb);
                    CSR_ACTION1: act_w[1]  <= apply_strb(act_w[1], reg_wr_data, reg_wr_strb);
                    CSR_ACTION2: act_w[2]  <= apply_strb(act_w[2], reg_wr_data, reg_wr_strb);
                    CSR_ACTION3: act_w[3]  <= apply_strb(act_w[3], reg_wr_data, reg_wr_strb);
                    default: ;
                endcase
            end
        end
    end

    // A clear in the same cycle as a lookup wins over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (cnt_clear) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (s_hs && first_beat) begin
            if (pkt_hit) hit_cnt  <= hit_cnt + 32'd1;
            else         miss_cnt <= miss_cnt + 32'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_word)
            CSR_INDEX:    rd_mux = 32'(index_reg);
            CSR_VALUE:    rd_mux = value_reg;
            CSR_MASK:     rd_mux = mask_reg;
            CSR_ACTION0:  rd_mux = act_w[0];
            CSR_ACTION1:  rd_mux = act_w[1];
            CSR_ACTION2:  rd_mux = act_w[2];
            CSR_ACTION3:  rd_mux = act_w[3];
            CSR_HIT_CNT:  rd_mux = hit_cnt;
            CSR_MISS_CNT: rd_mux = miss_cnt;
            default:      rd_mux = '0;
        endcase
    end

    // Read data is forced to zero outside the ack cycle so the parent can OR it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_rd_ack  <= 1'b0;
            reg_rd_data <= '0;
        end else begin
            reg_rd_ack  <= rd_accept;
            reg_rd_data <= rd_accept ? rd_mux : '0;
        end
    end

    l3fwd_mat_tcam #(
        .ADDR_WIDTH (TCAM_ADDR_WIDTH),
        .KEY_WIDTH  (TCAM_WR_WIDTH),
        .ACTN_WIDTH (ACTN_DATA_WIDTH)
    ) u_tcam (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (commit),
        .wr_addr    (index_reg),
        .wr_value   (value_reg),
        .wr_mask    (mask_reg),
        .wr_action  (ACTN_DATA_WIDTH'(act_w)),
        .wr_valid   (reg_wr_data[CMD_VALID_BIT]),
        .key        (key),
        .hit        (tcam_hit),
        .hit_index  (unused_hit_index),
        .hit_action (tcam_action)
    );

endmodule

// File: tb/tb_l3fwd_mat.sv
// Directed bench for l3fwd_mat: table programming over CSR, lookup results on
// tuser, priority, misses, backpressure, CSR timing and asynchronous reset.
`timescale 1ns/1ps
module tb_l3fwd_mat;

    localparam int DW   = 512;
    localparam int KW   = DW / 8;
    localparam int IDW  = 8;
    localparam int DSTW = 4;
    localparam int UW   = 4;
    localparam int AW   = 16;
    localparam int MUW  = UW + 128;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [IDW-1:0]  s_axis_tid;
    logic [DSTW-1:0] s_axis_tdest;
    logic [UW-1:0]   s_axis_tuser;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [IDW-1:0]  m_axis_tid;
    logic [DSTW-1:0] m_axis_tdest;
    logic [MUW-1:0]  m_axis_tuser;
    logic [AW-1:0]   reg_wr_addr;
    logic [31:0]     reg_wr_data;
    logic [3:0]      reg_wr_strb;
    logic            reg_wr_en;
    logic            reg_wr_wait;
    logic            reg_wr_ack;
    logic [AW-1:0]   reg_rd_addr;
    logic            reg_rd_en;
    logic [31:0]     reg_rd_data;
    logic            reg_rd_wait;
    logic            reg_rd_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0]   data;
        logic [KW-1:0]   keep;
        logic            last;
        logic [IDW-1:0]  id;
        logic [DSTW-1:0] dest;
        logic [MUW-1:0]  user;
    } beat_t;

    beat_t out_q[$];

    always #5 clk = ~clk;

    l3fwd_mat dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strb   (reg_wr_strb),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_wait   (reg_wr_wait),
        .reg_wr_ack    (reg_wr_ack),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_data   (reg_rd_data),
        .reg_rd_wait   (reg_rd_wait),
        .reg_rd_ack    (reg_rd_ack)
    );

    // Egress monitor: inputs change just after posedge, so negedge sees the
    // values that decide the next transfer.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst && m_axis_tvalid && m_axis_tready) begin
                b.data = m_axis_tdata; b.keep = m_axis_tkeep; b.last = m_axis_tlast;
                b.id = m_axis_tid; b.dest = m_axis_tdest; b.user = m_axis_tuser;
                out_q.push_back(b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] make_hdr(input logic [15:0] etype, input logic [31:0] ip,
                                               input logic [7:0] seed);
        logic [DW-1:0] d;
        for (int n = 0; n < DW/8; n++) d[8*n +: 8] = seed + 8'(n);
        d[8*12 +: 8] = etype[15:8];
        d[8*13 +: 8] = etype[7:0];
        d[8*30 +: 8] = ip[31:24];
        d[8*31 +: 8] = ip[23:16];
        d[8*32 +: 8] = ip[15:8];
        d[8*33 +: 8] = ip[7:0];
        return d;
    endfunction

    function automatic logic [DW-1:0] beat_data(input logic [DW-1:0] first, input int k);
        return (k == 0) ? first : first ^ {16{32'(k) * 32'h0101_0101}};
    endfunction

    function automatic logic [KW-1:0] keep_of(input int k, input int n);
        return (k == n - 1) ? 64'h00FF_FFFF_FFFF_FFFF : {KW{1'b1}};
    endfunction

    task automatic csr_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic ack);
        reg_wr_addr = addr; reg_wr_data = data; reg_wr_strb = strb; reg_wr_en = 1'b1;
        @(posedge clk); #1;
        ack = reg_wr_ack;
        reg_wr_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic csr_read(input logic [15:0] addr, output logic [31:0] data,
                            output logic ack, output logic ack_after);
        reg_rd_addr = addr; reg_rd_en = 1'b1;
        @(posedge clk); #1;
        ack = reg_rd_ack;
        data = reg_rd_data;
        reg_rd_en = 1'b0;
        @(posedge clk); #1;
        ack_after = reg_rd_ack;
    endtask

    task automatic program_entry(input logic [31:0] idx, input logic [31:0] val,
                                 input logic [31:0] msk, input logic [127:0] act, input logic vld);
        logic a;
        csr_write(16'h0010, idx, 4'hF, a);
        csr_write(16'h0014, val, 4'hF, a);
        csr_write(16'h0018, msk, 4'hF, a);
        csr_write(16'h0020, act[31:0], 4'hF, a);
        csr_write(16'h0024, act[63:32], 4'hF, a);
        csr_write(16'h0028, act[95:64], 4'hF, a);
        csr_write(16'h002C, act[127:96], 4'hF, a);
        csr_write(16'h001C, {30'h0, vld, 1'b1}, 4'hF, a);
    endtask

    task automatic send_pkt(input logic [DW-1:0] first, input int nbeats, input logic [UW-1:0] user,
                            input logic [IDW-1:0] id, input logic [DSTW-1:0] dest);
        for (int k = 0; k < nbeats; k++) begin
            int waited;
            logic rdy;
            s_axis_tdata = beat_data(first, k);
            s_axis_tkeep = keep_of(k, nbeats);
            s_axis_tlast = (k == nbeats - 1);
            s_axis_tid = id; s_axis_tdest = dest; s_axis_tuser = user;
            s_axis_tvalid = 1'b1;
            waited = 0;
            do begin
                @(negedge clk); rdy = s_axis_tready;
                @(posedge clk); #1; waited++;
            end while (!rdy && waited < 50);
            if (!rdy) begin
                checks++; errors++;
                $display("FAIL send_timeout beat %0d: tready stayed %b, required 1", k, rdy);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic wait_out(input int n, output logic ok);
        int waited = 0;
        while (out_q.size() < n && waited < 40) begin
            @(posedge clk); #1; waited++;
        end
        ok = (out_q.size() >= n);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL out_timeout: got %0d beats, required %0d", out_q.size(), n);
        end
    endtask

    task automatic read_counters(input logic [31:0] exp_hit, input logic [31:0] exp_miss,
                                 output logic [31:0] hit, output logic [31:0] miss);
        logic a, a2;
        csr_read(16'h0030, hit, a, a2);
        csr_read(16'h0034, miss, a, a2);
        if (exp_hit == exp_miss) begin end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic a, a2;
        rst = 1'b1;
        s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
        s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0; m_axis_tready = 1'b1;
        reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0; reg_wr_en = 0;
        reg_rd_addr = '0; reg_rd_en = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || reg_wr_ack !== 1'b0 || reg_rd_ack !== 1'b0
            || reg_rd_data !== 32'h0 || reg_wr_wait !== 1'b0 || reg_rd_wait !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: tvalid=%b tready=%b wack=%b rack=%b rdata=%h, required 0 1 0 0 0",
                     m_axis_tvalid, s_axis_tready, reg_wr_ack, reg_rd_ack, reg_rd_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        csr_read(16'h0030, d, a, a2);
        checks++;
        if (d !== 32'h0 || a !== 1'b1) begin errors++; $display("FAIL reset_hit_cnt: got %h ack %b, required 0 ack 1", d, a); end
        csr_read(16'h0034, d, a, a2);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_miss_cnt: got %h, required 0", d); end
        csr_read(16'h0010, d, a, a2);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_index: got %h, required 0", d); end
    endtask

    task automatic test_basic_hit();
        logic [DW-1:0] hdr;
        logic [MUW-1:0] exp_user;
        beat_t b;
        logic ok, a, a2;
        logic [31:0] d;
        program_entry(5, 32'hC0A8_0100, 32'hFFFF_FF00, 128'hAB, 1'b1);
        hdr = make_hdr(16'h0800, 32'hC0A8_0107, 8'h10);
        exp_user = {128'hAB, 4'h5};
        out_q.delete();
        send_pkt(hdr, 3, 4'h5, 8'h3C, 4'h9);
        wait_out(3, ok);
        for (int k = 0; k < 3 && ok; k++) begin
            b = out_q.pop_front();
            checks++;
            if (b.user !== exp_user) begin errors++; $display("FAIL hit_user beat %0d: got %h, required %h", k, b.user, exp_user); end
            checks++;
            if (b.data !== beat_data(hdr, k) || b.keep !== keep_of(k, 3)) begin
                errors++; $display("FAIL hit_data beat %0d: got keep %h data %h", k, b.keep, b.data);
            end
            checks++;
            if (b.last !== (k == 2) || b.id !== 8'h3C || b.dest !== 4'h9) begin
                errors++; $display("FAIL hit_side beat %0d: got last=%b id=%h dest=%h, required last=%b id=3c dest=9", k, b.last, b.id, b.dest, (k == 2));
            end
        end
        csr_read(16'h0030, d, a, a2);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL hit_cnt_after_hit: got %0d, required 1", d); end
    endtask

    task automatic test_priority();
        logic [DW-1:0] hdr;
        logic [MUW-1:0] exp_user;
        beat_t b;
        logic ok;
        program_entry(7, 32'h0A00_0001, 32'hFFFF_FFFF, 128'h77, 1'b1);
        program_entry(2, 32'h0A00_0000, 32'hFF00_0000, {32'h8000_0001, 64'h0, 32'h22}, 1'b1);
        hdr = make_hdr(16'h0800, 32'h0A00_0001, 8'h40);
        exp_user = {32'h8000_0001, 64'h0, 32'h22, 4'hA};
        out_q.delete();
        send_pkt(hdr, 2, 4'hA, 8'h01, 4'h2);
        wait_out(2, ok);
        for (int k = 0; k < 2 && ok; k++) begin
            b = out_q.pop_front();
            checks++;
            if (b.user !== exp_user) begin errors++; $display("FAIL prio_user beat %0d: got %h, required %h", k, b.user, exp_user); end
        end
    endtask

    task automatic test_miss();
        logic [DW-1:0] hdr;
        beat_t b;
        logic ok, a, a2;
        logic [31:0] d;
        out_q.delete();
        send_pkt(make_hdr(16'h86DD, 32'hC0A8_0107, 8'h80), 1, 4'h3, 8'h11, 4'h1);
        hdr = make_hdr(16'h0800, 32'h0808_0808, 8'h90);
        send_pkt(hdr, 2, 4'h6, 8'h12, 4'h2);
        wait_out(3, ok);
        if (ok) begin
            b = out_q.pop_front();
            checks++;
            if (b.user !== {128'h0, 4'h3}) begin errors++; $display("FAIL miss_non_ipv4: got %h, required %h", b.user, {128'h0, 4'h3}); end
            for (int k = 0; k < 2; k++) begin
                b = out_q.pop_front();
                checks++;
                if (b.user !== {128'h0, 4'h6} || b.data !== beat_data(hdr, k)) begin
                    errors++; $display("FAIL miss_unmatched beat %0d: got user %h, required %h", k, b.user, {128'h0, 4'h6});
                end
            end
        end
        csr_read(16'h0034, d, a, a2);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL miss_cnt: got %0d, required 2", d); end
        csr_read(16'h0030, d, a, a2);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL hit_cnt_after_miss: got %0d, required 2", d); end
    endtask

    task automatic test_back_to_back();
        logic [MUW-1:0] exp_user [4];
        beat_t b;
        logic ok, a, a2;
        logic [31:0] d;
        exp_user[0] = {128'hAB, 4'h1};
        exp_user[1] = {32'h8000_0001, 64'h0, 32'h22, 4'h2};
        exp_user[2] = {32'h8000_0001, 64'h0, 32'h22, 4'h2};
        exp_user[3] = {128'h0, 4'h4};
        out_q.delete();
        send_pkt(make_hdr(16'h0800, 32'hC0A8_0109, 8'h01), 1, 4'h1, 8'h21, 4'h3);
        send_pkt(make_hdr(16'h0800, 32'h0A00_0001, 8'h02), 2, 4'h2, 8'h22, 4'h3);
        send_pkt(make_hdr(16'h0800, 32'h0B00_0001, 8'h03), 1, 4'h4, 8'h23, 4'h3);
        wait_out(4, ok);
        for (int k = 0; k < 4 && ok; k++) begin
            b = out_q.pop_front();
            checks++;
            if (b.user !== exp_user[k]) begin errors++; $display("FAIL b2b_user beat %0d: got %h, required %h", k, b.user, exp_user[k]); end
        end
        csr_read(16'h0030, d, a, a2);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL b2b_hit_cnt: got %0d, required 4", d); end
        csr_read(16'h0034, d, a, a2);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL b2b_miss_cnt: got %0d, required 3", d); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] hdr;
        beat_t b;
        logic ok;
        hdr = make_hdr(16'h0800, 32'hC0A8_0107, 8'h55);
        out_q.delete();
        m_axis_tready = 1'b0;
        fork
            send_pkt(hdr, 3, 4'h7, 8'h44, 4'h5);
            begin
                @(posedge clk); #1;
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hdr) begin
                    errors++; $display("FAIL bp_latency: tvalid=%b, required 1 with first beat one cycle after handshake", m_axis_tvalid);
                end
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== hdr || m_axis_tuser !== {128'hAB, 4'h7}) begin
                        errors++; $display("FAIL bp_hold cycle %0d: s_tready=%b m_tvalid=%b, required 0 1 with output stable", i, s_axis_tready, m_axis_tvalid);
                    end
                    if (i < 2) begin @(posedge clk); #1; end
                end
                m_axis_tready = 1'b1;
            end
        join
        wait_out(3, ok);
        for (int k = 0; k < 3 && ok; k++) begin
            b = out_q.pop_front();
            checks++;
            if (b.data !== beat_data(hdr, k) || b.user !== {128'hAB, 4'h7} || b.last !== (k == 2)) begin
                errors++; $display("FAIL bp_beat %0d: got user %h last %b, required %h last %b", k, b.user, b.last, {128'hAB, 4'h7}, (k == 2));
            end
        end
        checks++;
        if (out_q.size() != 0) begin errors++; $display("FAIL bp_extra_beats: got %0d extra, required 0", out_q.size()); end
    endtask

    task automatic test_csr();
        logic [31:0] d;
        logic a, a2;
        logic [3:0] pat;
        logic [31:0] held_data;
        csr_write(16'h0014, 32'h0, 4'hF, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL csr_wr_ack: got %b, required 1", a); end
        csr_write(16'h0014, 32'hDEAD_BEEF, 4'b0011, a);
        csr_read(16'h0014, d, a, a2);
        checks++;
        if (d !== 32'h0000_BEEF || a !== 1'b1 || a2 !== 1'b0) begin
            errors++; $display("FAIL csr_strb_read: got %h ack %b next %b, required 0000beef ack 1 next 0", d, a, a2);
        end
        csr_write(16'h0004, 32'h1234_5678, 4'hF, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL csr_wr_oob_ack: got %b, required 0", a); end
        csr_read(16'h0004, d, a, a2);
        checks++;
        if (d !== 32'h0 || a !== 1'b0) begin errors++; $display("FAIL csr_rd_oob: got %h ack %b, required 0 ack 0", d, a); end
        csr_read(16'h0038, d, a, a2);
        checks++;
        if (d !== 32'h0 || a !== 1'b0) begin errors++; $display("FAIL csr_rd_oob_high: got %h ack %b, required 0 ack 0", d, a); end
        csr_read(16'h001C, d, a, a2);
        checks++;
        if (d !== 32'h0 || a !== 1'b1) begin errors++; $display("FAIL csr_cmd_read: got %h ack %b, required 0 ack 1", d, a); end
        reg_rd_addr = 16'h0010; reg_rd_en = 1'b1;
        held_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pat[i] = reg_rd_ack;
            if (i == 0) held_data = reg_rd_data;
        end
        reg_rd_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pat !== 4'b0101 || held_data !== 32'd2) begin
            errors++; $display("FAIL csr_held_en: ack pattern %b data %h, required 0101 data 2", pat, held_data);
        end
        @(posedge clk); #1;
        csr_write(16'h0034, 32'h0, 4'hF, a);
        csr_read(16'h0030, d, a, a2);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL csr_clear_hit: got %0d, required 0", d); end
        csr_read(16'h0034, d, a, a2);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL csr_clear_miss: got %0d, required 0", d); end
    endtask

    task automatic test_commit_invalid();
        beat_t b;
        logic ok, a, a2;
        logic [31:0] d;
        csr_write(16'h0010, 32'd5, 4'hF, a);
        csr_write(16'h001C, 32'h1, 4'hF, a);
        out_q.delete();
        send_pkt(make_hdr(16'h0800, 32'hC0A8_0107, 8'h66), 1, 4'h8, 8'h31, 4'h6);
        send_pkt(make_hdr(16'h0800, 32'h0A00_0001, 8'h67), 1, 4'h9, 8'h32, 4'h6);
        wait_out(2, ok);
        if (ok) begin
            b = out_q.pop_front();
            checks++;
            if (b.user !== {128'h0, 4'h8}) begin errors++; $display("FAIL inval_entry5: got %h, required %h", b.user, {128'h0, 4'h8}); end
            b = out_q.pop_front();
            checks++;
            if (b.user !== {32'h8000_0001, 64'h0, 32'h22, 4'h9}) begin
                errors++; $display("FAIL inval_entry2_kept: got %h, required %h", b.user, {32'h8000_0001, 64'h0, 32'h22, 4'h9});
            end
        end
        csr_read(16'h0034, d, a, a2);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL inval_miss_cnt: got %0d, required 1", d); end
        csr_read(16'h0030, d, a, a2);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL inval_hit_cnt: got %0d, required 1", d); end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        logic ok, a, a2;
        logic [31:0] d;
        out_q.delete();
        s_axis_tdata = make_hdr(16'h0800, 32'h0A00_0001, 8'h77);
        s_axis_tkeep = {KW{1'b1}}; s_axis_tlast = 1'b0; s_axis_tuser = 4'hB;
        s_axis_tvalid = 1'b1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_async_tvalid: got %b, required 0", m_axis_tvalid); end
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        out_q.delete();
        send_pkt(make_hdr(16'h0800, 32'h0A00_0001, 8'h78), 1, 4'hC, 8'h33, 4'h7);
        wait_out(1, ok);
        if (ok) begin
            b = out_q.pop_front();
            checks++;
            if (b.user !== {128'h0, 4'hC}) begin errors++; $display("FAIL rst_table_cleared: got %h, required %h", b.user, {128'h0, 4'hC}); end
        end
        csr_read(16'h0034, d, a, a2);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL rst_miss_cnt: got %0d, required 1", d); end
        csr_read(16'h0010, d, a, a2);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rst_index: got %0d, required 0", d); end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_priority();
        test_miss();
        test_back_to_back();
        test_backpressure();
        test_csr();
        test_commit_invalid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
